// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer and its arithmetic unit.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    // Ops that occupy the unit for several cycles (mult/multu/div/divu).
    function automatic logic is_long_op(input logic [2:0] op);
        return op <= 3'd3;
    endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath: 64-bit products, quotient/remainder
// with MIPS signed semantics, and a divide-by-zero flag.
module md_alu
    import md_pkg::*;
(
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [2:0]  md_op,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] safe_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] quo_u;
    logic [31:0] rem_u;

    // Signed division works on magnitudes, then restores signs; this also
    // makes 0x80000000 / -1 wrap to 0x80000000 without a special case.
    always_comb begin
        prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        prod_u = {32'd0, src_a} * {32'd0, src_b};
        safe_b = (src_b == 32'd0) ? 32'd1 : src_b;
        abs_a  = src_a[31] ? (~src_a + 32'd1) : src_a;
        abs_b  = safe_b[31] ? (~safe_b + 32'd1) : safe_b;
        mag_q  = abs_a / abs_b;
        mag_r  = abs_a % abs_b;
        quo_u  = src_a / safe_b;
        rem_u  = src_a % safe_b;
        res_hi = 32'd0;
        res_lo = 32'd0;
        div_zero = 1'b0;
        case (md_op_t'(md_op))
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                res_lo   = (src_a[31] ^ safe_b[31]) ? (~mag_q + 32'd1) : mag_q;
                res_hi   = src_a[31] ? (~mag_r + 32'd1) : mag_r;
                div_zero = (src_b == 32'd0);
            end
            MD_DIVU: begin
                res_lo   = quo_u;
                res_hi   = rem_u;
                div_zero = (src_b == 32'd0);
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO owner for the pipeline: sequences multi-cycle mult/div latency,
// handles mthi/mtlo, and raises the D-stage stall request.
module md_sequencer
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_instr_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] count;
    logic [31:0]   pending_hi;
    logic [31:0]   pending_lo;
    logic          pending_skip;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic          div_zero;
    logic          last_cycle;

    md_alu u_alu (
        .src_a    (src_a),
        .src_b    (src_b),
        .md_op    (md_op),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    assign last_cycle = (count == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start && (md_op == MD_MULT || md_op == MD_MULTU)) next_state = S_MULT;
                else if (start && (md_op == MD_DIV || md_op == MD_DIVU)) next_state = S_DIV;
            end
            S_MULT, S_DIV: begin
                if (last_cycle) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Results are computed at accept time and held until the latency expires;
    // a divide by zero still runs the full latency but never commits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            pending_hi   <= 32'd0;
            pending_lo   <= 32'd0;
            pending_skip <= 1'b0;
            hi           <= 32'd0;
            lo           <= 32'd0;
        end else if (state == S_IDLE) begin
            if (start) begin
                case (md_op_t'(md_op))
                    MD_MULT, MD_MULTU: begin
                        pending_hi   <= res_hi;
                        pending_lo   <= res_lo;
                        pending_skip <= 1'b0;
                        count        <= CW'(MULT_CYCLES);
                    end
                    MD_DIV, MD_DIVU: begin
                        pending_hi   <= res_hi;
                        pending_lo   <= res_lo;
                        pending_skip <= div_zero;
                        count        <= CW'(DIV_CYCLES);
                    end
                    MD_MTHI: hi <= src_a;
                    MD_MTLO: lo <= src_a;
                    default: ;
                endcase
            end
        end else if (last_cycle) begin
            count <= '0;
            if (!pending_skip) begin
                hi <= pending_hi;
                lo <= pending_lo;
            end
        end else begin
            count <= count - CW'(1);
        end
    end

    assign busy     = (state != S_IDLE);
    assign stall_md = md_instr_D & (busy | (start & is_long_op(md_op)));

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed vector table, hand-written
// corner sequences, and randomized ops against an arithmetic reference model.
module tb_md_sequencer;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_instr_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        string       name;
    } vec_t;

    vec_t vecs[6];

    md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .md_op      (md_op),
        .src_a      (src_a),
        .src_b      (src_b),
        .md_instr_D (md_instr_D),
        .busy       (busy),
        .stall_md   (stall_md),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = sa * sb; model_hi = p[63:32]; model_lo = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; model_hi = p[63:32]; model_lo = p[31:0]; end
            3'd2: if (b != 0) begin
                sq = sa / sb; sr = sa % sb;
                p = sq; model_lo = p[31:0];
                p = sr; model_hi = p[31:0];
            end
            3'd3: if (b != 0) begin model_lo = a / b; model_hi = a % b; end
            3'd4: model_hi = a;
            3'd5: model_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op, then check stall, the busy window length and final HI/LO.
    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic instr_d, input logic [31:0] exp_hi,
                                  input logic [31:0] exp_lo, input string name);
        int n;
        n = (op <= 3'd1) ? MULT_N : (op <= 3'd3) ? DIV_N : 0;
        @(negedge clk);
        start = 1'b1; md_op = op; src_a = a; src_b = b; md_instr_D = instr_d;
        #1;
        check_output({name, " stall_at_start"}, 32'(stall_md), 32'(instr_d && op <= 3'd3));
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_output($sformatf("%s busy_c%0d", name, i + 1), 32'(busy), 32'd1);
            check_output($sformatf("%s stall_c%0d", name, i + 1), 32'(stall_md), 32'(instr_d));
        end
        @(negedge clk);
        check_output({name, " busy_done"}, 32'(busy), 32'd0);
        check_output({name, " stall_done"}, 32'(stall_md), 32'd0);
        check_output({name, " hi"}, hi, exp_hi);
        check_output({name, " lo"}, lo, exp_lo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          sel;

        vecs[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg2x3"};
        vecs[1] = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, "multu_max_x2"};
        vecs[2] = '{3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, "divu_7_2"};
        vecs[3] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2"};
        vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_min_neg1"};
        vecs[5] = '{3'd2, 32'd5,        32'd0,        32'h00000000, 32'h80000000, "div_by_zero"};

        reset = 1'b1; start = 1'b0; md_op = 3'd0; src_a = 32'd0; src_b = 32'd0; md_instr_D = 1'b0;
        #1;
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset hi", hi, 32'd0);
        check_output("reset lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].name);
            model_hi = vecs[i].exp_hi;
            model_lo = vecs[i].exp_lo;
        end

        // mult with no HI/LO consumer in D: no stall at any point
        model_apply(3'd0, 32'd6, 32'd7);
        apply_stimulus(3'd0, 32'd6, 32'd7, 1'b0, model_hi, model_lo, "mult_no_dep");

        // reserved op: nothing happens, no stall
        apply_stimulus(3'd6, 32'hDEADBEEF, 32'd1, 1'b1, model_hi, model_lo, "reserved_op");

        // mthi then mtlo back to back
        @(negedge clk);
        start = 1'b1; md_op = 3'd4; src_a = 32'h12345678; md_instr_D = 1'b1;
        #1 check_output("mthi stall", 32'(stall_md), 32'd0);
        @(negedge clk);
        md_op = 3'd5; src_a = 32'h9ABCDEF0;
        #1;
        check_output("mthi hi", hi, 32'h12345678);
        check_output("mthi busy", 32'(busy), 32'd0);
        check_output("mtlo stall", 32'(stall_md), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check_output("mtlo lo", lo, 32'h9ABCDEF0);
        check_output("mtlo hi_kept", hi, 32'h12345678);
        check_output("mtlo busy", 32'(busy), 32'd0);
        model_hi = 32'h12345678;
        model_lo = 32'h9ABCDEF0;

        // reset in cycle 3 of a div aborts it with no late commit
        @(negedge clk);
        start = 1'b1; md_op = 3'd3; src_a = 32'd100; src_b = 32'd7; md_instr_D = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("pre_reset busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_output("async_reset busy", 32'(busy), 32'd0);
        check_output("async_reset stall", 32'(stall_md), 32'd0);
        check_output("async_reset hi", hi, 32'd0);
        check_output("async_reset lo", lo, 32'd0);
        #2 reset = 1'b0;
        repeat (12) @(negedge clk);
        check_output("post_reset hi", hi, 32'd0);
        check_output("post_reset lo", lo, 32'd0);
        check_output("post_reset busy", 32'(busy), 32'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;

        // randomized ops against the reference model
        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            rb  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 9)) : $urandom;
            if (sel == 2) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            if (sel == 3) ra = 32'($urandom_range(0, 100));
            model_apply(rop, ra, rb);
            apply_stimulus(rop, ra, rb, 1'($urandom_range(0, 1)), model_hi, model_lo,
                           $sformatf("rand%0d_op%0d", k, rop));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
Multiply/divide sequencer that owns the HI/LO registers for the 5-stage MIPS pipeline.
- Accepts mult/div/mthi/mtlo ops from the E stage.
- Models multi-cycle MULT/DIV latency with a busy counter.
- Generates the stall request that holds the D stage while a HI/LO-dependent instruction would collide with an in-flight operation.
- HI/LO values feed mfhi/mflo and the M-stage HILO forwarding path.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  E-stage instruction is a valid md op this cycle
md_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved
src_a  in  32  forwarded rs value from E stage
src_b  in  32  forwarded rt value from E stage
md_instr_D  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
busy  out  1  operation in flight
stall_md  out  1  stall request to the hazard unit (freeze PC/D, bubble E)
hi  out  32  current HI register
lo  out  32  current LO register

Behaviour:
- Reset (async, active-high):
  - state=IDLE, count=0, busy=0.
  - hi=0, lo=0, and the pending result registers are cleared.
  - Reset mid-operation aborts the operation; HI/LO do not update.
- States and transitions:
  - IDLE, start with md_op 0/1 -> MULT: compute the 64-bit product into pending_hi/pending_lo; count<=MULT_CYCLES.
  - IDLE, start with md_op 2/3 -> DIV: compute quotient to pending_lo and remainder to pending_hi; count<=DIV_CYCLES.
  - IDLE, start with md_op 4/5: hi<=src_a (mthi) or lo<=src_a (mtlo) at that edge; stays IDLE; busy stays 0.
  - MULT/DIV: count decrements each cycle.
  - MULT/DIV at count==1: hi<=pending_hi, lo<=pending_lo, count<=0, -> IDLE.
- Latency:
  - start sampled at edge t0.
  - busy=1 for exactly N cycles after t0 (N = MULT_CYCLES or DIV_CYCLES).
  - New HI/LO are visible in the first cycle busy=0.
  - busy is registered: busy = (state != IDLE).
- Stall:
  - stall_md = md_instr_D & (busy | (start & md_op<=3)). Combinational.
  - mthi/mtlo in E never stall D.
- start while busy: ignored; no state change. The hazard unit guarantees this cannot occur.
- Arithmetic:
  - mult: signed 32x32->64; multu: unsigned.
  - div: signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - divu: unsigned.
  - div by zero (src_b==0): HI/LO unchanged at completion, but the full busy latency is still observed.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Reserved md_op (6,7) with start: treated as no-op; no busy, no stall contribution.
- hi/lo are direct register outputs and do not change combinationally with inputs.

Decomposition:
- Shared package md_pkg:
  - md_op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - state encoding: S_IDLE, S_MULT, S_DIV.
- One sub-module md_alu: purely combinational.
  - Inputs: src_a, src_b, md_op.
  - Outputs: res_hi, res_lo, div_zero.
  - Implements all signed/unsigned and corner-case rules.
- md_sequencer holds the FSM, counter, pending registers, HI/LO and stall logic.

Test Plan:
- mult: start, md_op=0, src_a=0xFFFFFFFE (-2), src_b=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=0.
- multu and divu:
  - multu 0xFFFFFFFF * 2 -> hi=1, lo=0xFFFFFFFE after 5 cycles.
  - divu 7/2 -> lo=3, hi=1 after 10 cycles.
- Signed div:
  - div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
  - div 5/0 -> busy 10 cycles; HI/LO keep prior values.
- Stall:
  - md_instr_D=1 in the same cycle as a mult start -> stall_md=1.
  - stall_md stays 1 for all 5 busy cycles and drops in the cycle busy falls.
  - md_instr_D=0 while busy -> stall_md=0.
- mthi/mtlo: mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles -> hi/lo update on the next edge; busy and stall_md stay 0.
- Reset: assert reset in cycle 3 of a div -> busy=0, hi=lo=0 immediately (asynchronous); no late HI/LO write after release.
